// File: rtl/sim_ram_arbiter.sv
// sim_ram_arbiter
//   Shares one SimRAM (1 read port + 1 write port, 1-cycle read latency) between
//   NUM_REQ requesters. Round-robin arbitration, one RAM access per cycle.
//   Read responses are returned one cycle after the handshake on a shared data bus
//   with a one-hot per-requester valid.
//
//   Optional: define SIM_RAM_ARB_STATS_EN to add saturating per-requester
//   grant and stall counters (stat_grants_o / stat_stalls_o).
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/we_i      per-requester request valid / write-enable
//   req_addr_i/wdata_i    packed per-requester address / write data
//   req_ready_o           one-hot grant (handshake = valid & ready)
//   rsp_valid_o           one-hot read-response valid
//   rsp_rdata_o           read data, shared, 0 when no response
//   ram_rd_*/ram_wr_*     SimRAM read/write port
//   stat_grants_o/stalls_o per-requester counters (stats build only)
`timescale 1ns/1ps
module sim_ram_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_SIZE  = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int DATA_WIDTH = 8 * DATA_SIZE
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
  output logic                          ram_rd_en_o,
  output logic [ADDR_WIDTH-1:0]         ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]         ram_rd_data_i,
  output logic                          ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0]         ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0]         ram_wr_data_o
`ifdef SIM_RAM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  stat_grants_o,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  stat_stalls_o
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic                  rsp_pend_q, rsp_pend_d;
  logic [ID_W-1:0]       gnt_id;
  logic                  gnt_any;
  logic [NUM_REQ-1:0]    gnt;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  // Nothing is granted while in reset, so no handshake can happen then.
  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_any && req_valid_i[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
    if (rst_i) gnt_any = 1'b0;
    if (gnt_any) gnt[gnt_id] = 1'b1;
  end

  assign req_ready_o = gnt;
  assign sel_we      = req_we_i[gnt_id];
  assign sel_addr    = req_addr_i[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata   = req_wdata_i[gnt_id*DATA_WIDTH +: DATA_WIDTH];

  // Inactive RAM port fields are forced to 0.
  always_comb begin
    ram_rd_en_o   = gnt_any && !sel_we;
    ram_wr_en_o   = gnt_any &&  sel_we;
    ram_rd_addr_o = ram_rd_en_o ? sel_addr  : '0;
    ram_wr_addr_o = ram_wr_en_o ? sel_addr  : '0;
    ram_wr_data_o = ram_wr_en_o ? sel_wdata : '0;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rsp_pend_d = ram_rd_en_o;
    rsp_id_d   = gnt_id;
    if (gnt_any)
      rr_ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      rsp_pend_q <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  // A read tagged in the cycle before reset rises must not surface while rst is
  // high, so the response is also gated combinationally by rst_i.
  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    if (rsp_pend_q && !rst_i) begin
      rsp_valid_o[rsp_id_q] = 1'b1;
      rsp_rdata_o           = ram_rd_data_i;
    end
  end

`ifdef SIM_RAM_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] grants_q, stalls_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        grants_q[i] <= '0;
        stalls_q[i] <= '0;
      end else begin
        if (gnt[i] && !(&grants_q[i]))
          grants_q[i] <= grants_q[i] + 1'b1;
        if (req_valid_i[i] && !gnt[i] && !(&stalls_q[i]))
          stalls_q[i] <= stalls_q[i] + 1'b1;
      end
    end
  end

  assign stat_grants_o = grants_q;
  assign stat_stalls_o = stalls_q;
`else
  // Statistics disabled: no counter state.
`endif

endmodule
